// File: rtl/rf_pkg.sv
// Shared types, defaults and read-address unpacking for rf_multiport.
package rf_pkg;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 3;
  localparam int RD_ADDR_MAX_W = 8;
  localparam int RD_BUS_MAX_W  = 4 * RD_ADDR_MAX_W;

  typedef logic [DEF_DATA_W-1:0] rf_word_t;

  // Extract read port k's address from a packed bus of aw-bit fields.
  function automatic logic [RD_ADDR_MAX_W-1:0] rd_addr(input logic [RD_BUS_MAX_W-1:0] bus,
                                                       input int k, input int aw);
    logic [RD_BUS_MAX_W-1:0] s;
    s = bus >> (k * aw);
    return RD_ADDR_MAX_W'(s) & RD_ADDR_MAX_W'((1 << aw) - 1);
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits: writes clear, issue sets, set wins on collision.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int R0_ZERO = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [ADDR_W-1:0]    set_addr,
  input  logic                 clr_en_0,
  input  logic [ADDR_W-1:0]    clr_addr_0,
  input  logic                 clr_en_1,
  input  logic [ADDR_W-1:0]    clr_addr_1,
  output logic [2**ADDR_W-1:0] pending
);
  logic [2**ADDR_W-1:0] nxt;

  always_comb begin
    nxt = pending;
    if (clr_en_0) nxt[clr_addr_0] = 1'b0;
    if (clr_en_1) nxt[clr_addr_1] = 1'b0;
    if (set_en)   nxt[set_addr]   = 1'b1;
    if (R0_ZERO != 0) nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= nxt;
  end
endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file with two prioritised write ports and a RAW scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int R0_ZERO = 0
) (
  input  logic                        In_clock,
  input  logic                        In_reset,
  input  logic [NUM_RD*ADDR_W-1:0]    In_RF_Read_addr,
  output logic [NUM_RD*DATA_W-1:0]    Out_RF_Read_data,
  output logic [NUM_RD-1:0]           Out_RF_Read_busy,
  input  logic                        In_RF_Write_en_0,
  input  logic                        In_RF_Write_en_1,
  input  logic [ADDR_W-1:0]           In_RF_Write_addr_0,
  input  logic [ADDR_W-1:0]           In_RF_Write_addr_1,
  input  logic [DATA_W-1:0]           In_RF_Write_data_0,
  input  logic [DATA_W-1:0]           In_RF_Write_data_1,
  input  logic                        In_SB_Set_en,
  input  logic [ADDR_W-1:0]           In_SB_Set_addr,
  output logic [DATA_W*2**ADDR_W-1:0] Out_RF_Regs,
  output logic [2**ADDR_W-1:0]        Out_SB_Pending
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]       regs [DEPTH];
  logic [DEPTH-1:0]        pending;
  logic                    w0_ok, w1_ok, set_ok;
  logic [RD_BUS_MAX_W-1:0] rd_bus;

  assign w0_ok  = In_RF_Write_en_0 && !(R0_ZERO != 0 && In_RF_Write_addr_0 == '0);
  assign w1_ok  = In_RF_Write_en_1 && !(R0_ZERO != 0 && In_RF_Write_addr_1 == '0);
  assign set_ok = In_SB_Set_en     && !(R0_ZERO != 0 && In_SB_Set_addr     == '0);
  assign rd_bus = RD_BUS_MAX_W'(In_RF_Read_addr);

  // Port 1 is written first so a same-address port 0 write overrides it.
  always_ff @(posedge In_clock) begin
    if (In_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (w1_ok) regs[In_RF_Write_addr_1] <= In_RF_Write_data_1;
      if (w0_ok) regs[In_RF_Write_addr_0] <= In_RF_Write_data_0;
    end
  end

  rf_scoreboard #(.ADDR_W(ADDR_W), .R0_ZERO(R0_ZERO)) u_sb (
    .clk        (In_clock),
    .rst        (In_reset),
    .set_en     (set_ok),
    .set_addr   (In_SB_Set_addr),
    .clr_en_0   (w0_ok),
    .clr_addr_0 (In_RF_Write_addr_0),
    .clr_en_1   (w1_ok),
    .clr_addr_1 (In_RF_Write_addr_1),
    .pending    (pending)
  );

  always_comb begin
    logic [ADDR_W-1:0] a;
    Out_RF_Read_data = '0;
    Out_RF_Read_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = ADDR_W'(rd_addr(rd_bus, k, ADDR_W));
      Out_RF_Read_data[k*DATA_W +: DATA_W] = regs[a];
      Out_RF_Read_busy[k] = pending[a];
`ifdef RF_BYPASS_EN
      if (w1_ok && In_RF_Write_addr_1 == a) begin
        Out_RF_Read_data[k*DATA_W +: DATA_W] = In_RF_Write_data_1;
        Out_RF_Read_busy[k] = set_ok && In_SB_Set_addr == a;
      end
      if (w0_ok && In_RF_Write_addr_0 == a) begin
        Out_RF_Read_data[k*DATA_W +: DATA_W] = In_RF_Write_data_0;
        Out_RF_Read_busy[k] = set_ok && In_SB_Set_addr == a;
      end
`endif
      if ((R0_ZERO != 0 && a == '0) || In_reset) begin
        Out_RF_Read_data[k*DATA_W +: DATA_W] = '0;
        Out_RF_Read_busy[k] = 1'b0;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign Out_RF_Regs[i*DATA_W +: DATA_W] = regs[i];
  end
  assign Out_SB_Pending = pending;
endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport; two instances (R0_ZERO=0 and 1) share stimulus.
module tb_rf_multiport;
  import rf_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   rd_addr_bus;
  logic [31:0]  rd_data, rd_data_z;
  logic [1:0]   rd_busy, rd_busy_z;
  logic         we0, we1, set_en;
  logic [2:0]   wa0, wa1, set_addr;
  rf_word_t     wd0, wd1;
  logic [127:0] regs_o, regs_z;
  logic [7:0]   pend_o, pend_z;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_multiport #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .R0_ZERO(0)) dut (
    .In_clock(clk), .In_reset(rst), .In_RF_Read_addr(rd_addr_bus),
    .Out_RF_Read_data(rd_data), .Out_RF_Read_busy(rd_busy),
    .In_RF_Write_en_0(we0), .In_RF_Write_en_1(we1),
    .In_RF_Write_addr_0(wa0), .In_RF_Write_addr_1(wa1),
    .In_RF_Write_data_0(wd0), .In_RF_Write_data_1(wd1),
    .In_SB_Set_en(set_en), .In_SB_Set_addr(set_addr),
    .Out_RF_Regs(regs_o), .Out_SB_Pending(pend_o));

  rf_multiport #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .R0_ZERO(1)) dut_z (
    .In_clock(clk), .In_reset(rst), .In_RF_Read_addr(rd_addr_bus),
    .Out_RF_Read_data(rd_data_z), .Out_RF_Read_busy(rd_busy_z),
    .In_RF_Write_en_0(we0), .In_RF_Write_en_1(we1),
    .In_RF_Write_addr_0(wa0), .In_RF_Write_addr_1(wa1),
    .In_RF_Write_data_0(wd0), .In_RF_Write_data_1(wd1),
    .In_SB_Set_en(set_en), .In_SB_Set_addr(set_addr),
    .Out_RF_Regs(regs_z), .Out_SB_Pending(pend_z));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; set_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; set_addr = 0;
    rd_addr_bus = 6'o00;
    tick();
    n_cmp++; if (regs_o !== 128'h0) begin n_err++; $display("FAIL reset_regs: got %h want 0", regs_o); end
    n_cmp++; if (pend_o !== 8'h00) begin n_err++; $display("FAIL reset_pend: got %h want 00", pend_o); end
    n_cmp++; if (pend_z !== 8'h00) begin n_err++; $display("FAIL reset_pend_z: got %h want 00", pend_z); end
    rst = 0;
    tick();
    for (int a = 0; a < 8; a++) begin
      rd_addr_bus = {3'(7 - a), 3'(a)};
      #1;
      n_cmp++;
      if (rd_data !== 32'h0 || rd_busy !== 2'b00) begin
        n_err++; $display("FAIL reset_read a=%0d: got data %h busy %b want 0/00", a, rd_data, rd_busy);
      end
    end
  endtask

  task automatic test_write();
    we0 = 1; wa0 = 3; wd0 = 16'hBEEF;
    tick(); idle();
    rd_addr_bus = {3'd3, 3'd3};
    #1;
    n_cmp++; if (rd_data !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL write_read3: got %h want beefbeef", rd_data); end
    n_cmp++; if (regs_o[3*16 +: 16] !== 16'hBEEF) begin n_err++; $display("FAIL write_regs3: got %h want beef", regs_o[3*16 +: 16]); end
  endtask

  task automatic test_dual_write();
    we0 = 1; wa0 = 5; wd0 = 16'h1111;
    we1 = 1; wa1 = 5; wd1 = 16'h2222;
    tick();
    wa0 = 6; wd0 = 16'h6666; wa1 = 7; wd1 = 16'h7777;
    tick(); idle();
    rd_addr_bus = {3'd6, 3'd5};
    #1;
    n_cmp++; if (rd_data[15:0] !== 16'h1111) begin n_err++; $display("FAIL dual_same_addr: got %h want 1111", rd_data[15:0]); end
    n_cmp++; if (rd_data[31:16] !== 16'h6666) begin n_err++; $display("FAIL dual_w0_addr6: got %h want 6666", rd_data[31:16]); end
    n_cmp++; if (regs_o[7*16 +: 16] !== 16'h7777) begin n_err++; $display("FAIL dual_w1_addr7: got %h want 7777", regs_o[7*16 +: 16]); end
  endtask

  task automatic test_scoreboard();
    set_en = 1; set_addr = 2;
    tick(); idle();
    rd_addr_bus = {3'd5, 3'd2};
    #1;
    n_cmp++; if (rd_busy !== 2'b01) begin n_err++; $display("FAIL sb_set_busy: got %b want 01", rd_busy); end
    n_cmp++; if (pend_o !== 8'h04) begin n_err++; $display("FAIL sb_set_pend: got %h want 04", pend_o); end
    we0 = 1; wa0 = 2; wd0 = 16'h2020; set_en = 1; set_addr = 2;
    tick(); idle();
    n_cmp++; if (pend_o !== 8'h04) begin n_err++; $display("FAIL sb_set_wins: got %h want 04", pend_o); end
    n_cmp++; if (rd_data[15:0] !== 16'h2020) begin n_err++; $display("FAIL sb_write_data: got %h want 2020", rd_data[15:0]); end
    we1 = 1; wa1 = 2; wd1 = 16'h3030;
    tick(); idle();
    n_cmp++; if (pend_o !== 8'h00) begin n_err++; $display("FAIL sb_clear: got %h want 00", pend_o); end
    n_cmp++; if (rd_busy[0] !== 1'b0 || rd_data[15:0] !== 16'h3030) begin
      n_err++; $display("FAIL sb_clear_read: got busy %b data %h want 0/3030", rd_busy[0], rd_data[15:0]);
    end
  endtask

  task automatic test_bypass();
    // Old value 0044 with pending set on the same edge (set wins).
    we0 = 1; wa0 = 4; wd0 = 16'h0044; set_en = 1; set_addr = 4;
    tick(); idle();
    we1 = 1; wa1 = 4; wd1 = 16'h00AA;
    rd_addr_bus = {3'd4, 3'd1};
    #1;
`ifdef RF_BYPASS_EN
    n_cmp++; if (rd_data[31:16] !== 16'h00AA) begin n_err++; $display("FAIL bypass_data: got %h want 00aa", rd_data[31:16]); end
    n_cmp++; if (rd_busy[1] !== 1'b0) begin n_err++; $display("FAIL bypass_busy: got %b want 0", rd_busy[1]); end
`else
    n_cmp++; if (rd_data[31:16] !== 16'h0044) begin n_err++; $display("FAIL nobypass_data: got %h want 0044", rd_data[31:16]); end
    n_cmp++; if (rd_busy[1] !== 1'b1) begin n_err++; $display("FAIL nobypass_busy: got %b want 1", rd_busy[1]); end
`endif
    tick(); idle();
    n_cmp++; if (rd_data[31:16] !== 16'h00AA || rd_busy[1] !== 1'b0) begin
      n_err++; $display("FAIL bypass_next: got %h/%b want 00aa/0", rd_data[31:16], rd_busy[1]);
    end
  endtask

  task automatic test_r0_zero();
    we0 = 1; wa0 = 0; wd0 = 16'hFFFF; set_en = 1; set_addr = 0;
    tick(); idle();
    rd_addr_bus = {3'd3, 3'd0};
    #1;
    n_cmp++; if (rd_data[15:0] !== 16'hFFFF || rd_busy[0] !== 1'b1) begin
      n_err++; $display("FAIL r0_normal: got %h/%b want ffff/1", rd_data[15:0], rd_busy[0]);
    end
    n_cmp++; if (rd_data_z[15:0] !== 16'h0000 || rd_busy_z[0] !== 1'b0) begin
      n_err++; $display("FAIL r0_zero_read: got %h/%b want 0000/0", rd_data_z[15:0], rd_busy_z[0]);
    end
    n_cmp++; if (regs_z[15:0] !== 16'h0000 || pend_z[0] !== 1'b0) begin
      n_err++; $display("FAIL r0_zero_state: got %h/%b want 0000/0", regs_z[15:0], pend_z[0]);
    end
    n_cmp++; if (rd_data_z[31:16] !== 16'hBEEF) begin n_err++; $display("FAIL r0_zero_other: got %h want beef", rd_data_z[31:16]); end
  endtask

  task automatic test_reset_mid();
    set_en = 1; set_addr = 6;
    tick(); idle();
    rst = 1;
    we0 = 1; wa0 = 1; wd0 = 16'h1234; we1 = 1; wa1 = 6; wd1 = 16'h5678; set_en = 1; set_addr = 7;
    rd_addr_bus = {3'd6, 3'd3};
    #1;
    n_cmp++; if (rd_data !== 32'h0 || rd_busy !== 2'b00) begin
      n_err++; $display("FAIL reset_force: got %h/%b want 0/00", rd_data, rd_busy);
    end
    tick();
    n_cmp++; if (regs_o !== 128'h0 || pend_o !== 8'h00) begin
      n_err++; $display("FAIL reset_mid: got regs %h pend %h want 0/00", regs_o, pend_o);
    end
    n_cmp++; if (regs_z !== 128'h0 || pend_z !== 8'h00) begin
      n_err++; $display("FAIL reset_mid_z: got regs %h pend %h want 0/00", regs_z, pend_z);
    end
    rst = 0; idle();
    tick();
    n_cmp++; if (regs_o !== 128'h0 || rd_data !== 32'h0) begin
      n_err++; $display("FAIL reset_after: got regs %h data %h want 0", regs_o, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_dual_write();
    test_scoreboard();
    test_bypass();
    test_r0_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised multi-port register file for the RISC datapath: 2^ADDR_W entries of DATA_W bits, NUM_RD combinational read ports, and two synchronous write ports with fixed priority. It adds a per-register pending-write scoreboard so the decode stage can detect RAW hazards, plus optional write-to-read bypass. It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear) and replaces the fixed 8x16, 2R/1W file.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; depth = 2^ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- R0_ZERO, 0, 1 = entry 0 is hardwired to zero and ignores writes and scoreboard sets
- In_clock  in  1  clock; all state updates on rising edge
- In_reset  in  1  synchronous, active-high reset
- In_RF_Read_addr  in  NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- Out_RF_Read_data  out  NUM_RD*DATA_W  read data, packed the same way
- Out_RF_Read_busy  out  NUM_RD  1 = addressed register has a pending write
- In_RF_Write_en_0 / In_RF_Write_en_1  in  1 each  write enables; port 0 has priority
- In_RF_Write_addr_0 / In_RF_Write_addr_1  in  ADDR_W each  write addresses
- In_RF_Write_data_0 / In_RF_Write_data_1  in  DATA_W each  write data
- In_SB_Set_en  in  1  mark a register pending (instruction issued)
- In_SB_Set_addr  in  ADDR_W  register to mark
- Out_RF_Regs  out  DATA_W*2^ADDR_W  flattened register contents for debug; entry i = bits [i*DATA_W +: DATA_W]
- Out_SB_Pending  out  2^ADDR_W  scoreboard bits

## Operation
- Array: 2^ADDR_W x DATA_W registers. Scoreboard: 2^ADDR_W pending bits.
- Writes:
  - Each enabled write port commits on the rising edge.
  - If both ports target the same address, port 0 data is stored and port 1 is dropped.
- Scoreboard clear: a committed write to address A clears pending[A].
- Scoreboard set:
  - In_SB_Set_en sets pending[In_SB_Set_addr].
  - If set and clear hit the same address in one cycle, set wins and pending stays 1.
- Reads:
  - Combinational: Out_RF_Read_data[k] = array[addr_k].
  - Out_RF_Read_busy[k] = pending[addr_k].
- R0_ZERO=1: reads of address 0 return 0 with busy 0. Writes and sets to address 0 are ignored.
- Reset, while In_reset=1 at a clock edge:
  - All array entries become 0.
  - All pending bits become 0.
  - Writes and sets in that cycle are ignored.
  - Reset takes effect mid-operation in any cycle.
- While In_reset is high, Out_RF_Read_data and Out_RF_Read_busy are forced to 0 combinationally.
- Address out of range cannot occur, since depth is a power of two.

## Timing
- Write latency: data written at edge N is visible on a non-bypassed read from N onward, i.e. the cycle after the write is presented.
- Read latency: 0 cycles (combinational).
- Scoreboard set at edge N: busy is visible from N onward.
- Reset values:
  - Out_RF_Regs = 0.
  - Out_SB_Pending = 0.
  - Out_RF_Read_data = 0.
  - Out_RF_Read_busy = 0.
- No handshake: the writer must not assert a write without a prior set. The block does not check this; a stray write still commits and clears.

## Configuration
- RF_BYPASS_EN defined:
  - Each read port compares its address against both write ports in the same cycle.
  - On a match it returns the write data, with port 0 taking priority, and reports busy=0 unless a same-cycle set targets that address.
  - Address 0 is excluded when R0_ZERO=1.
- RF_BYPASS_EN undefined:
  - Reads always return array contents and stored pending bits.
  - A same-cycle write is seen one cycle later.

## Structure
- Package rf_pkg holds:
  - default DATA_W/ADDR_W localparams
  - a typedef for the register word
  - a function that unpacks read port k from the packed address bus
- Sub-module rf_scoreboard (pending bits, set/clear priority, reset) is natural. The array, write arbitration and read/bypass muxes stay in rf_multiport.

## Test plan
- Reset then read all 8 addresses -> data 0, busy 0; Out_SB_Pending=8'h00.
- Write W0 addr 3 = 16'hBEEF, next cycle read port 0 addr 3 -> 16'hBEEF; Out_RF_Regs entry 3 = 16'hBEEF.
- W0 and W1 both write addr 5 (16'h1111 / 16'h2222) -> addr 5 reads 16'h1111.
- Set addr 2; next cycle busy=1 on a read of 2; at the same edge as a write of 2, assert a new set on 2 -> pending[2] stays 1. After a further write alone -> pending[2]=0.
- With RF_BYPASS_EN: same-cycle W1 write addr 4 = 16'h00AA, read 4 -> 16'h00AA immediately. Without the macro -> old value that cycle, 16'h00AA the next.
- R0_ZERO=1: write 16'hFFFF to addr 0 and set addr 0 -> read 0, busy 0. Assert reset mid-sequence with writes active -> all entries and pending bits 0 after the edge.
